uart_tx_ctrl: RTL

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl_if.sv | 28 ++
 rtl/uart_tx_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Interface between the UART transmit controller and its surroundings:
// the frame request side (P_DATA, Data_Valid, parity options), the
// serializer handshake (data_reg, ser_en, ser_done) and line/status outputs.
interface uart_tx_ctrl_if;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       ser_done;
  logic [7:0] data_reg;
  logic       ser_en;
  logic [1:0] mux_sel;
  logic       par_bit;
  logic       busy;
  logic       frame_err;

  // Requester / serializer side: drives requests and completion pulses.
  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_done,
    input  data_reg, ser_en, mux_sel, par_bit, busy, frame_err
  );

  // Controller side.
  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_done,
    output data_reg, ser_en, mux_sel, par_bit, busy, frame_err
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller. Sequences START, DATA (serializer
// enabled), optional PARITY and STOP, latching the byte and its parity bit
// when a frame is accepted. A watchdog ends a DATA phase that lasts nine
// cycles without ser_done; frame_err is registered so it appears, glitch
// free, during the STOP cycle that follows the timeout.
module uart_tx_ctrl (
  input  logic           clk,
  input  logic           reset,
  uart_tx_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Line mux encodings.
  localparam logic [1:0] MUX_START  = 2'b00;
  localparam logic [1:0] MUX_STOP   = 2'b01;
  localparam logic [1:0] MUX_DATA   = 2'b10;
  localparam logic [1:0] MUX_PARITY = 2'b11;

  // DATA cycles already completed when the ninth one is in progress.
  localparam logic [3:0] WD_LAST = 4'd8;

  state_t      state_reg, state_next;
  logic [3:0]  wd_reg, wd_next;
  logic [7:0]  byte_reg;
  logic        par_en_reg;
  logic        par_bit_reg;
  logic        frame_err_reg;
  logic        accept;
  logic        timeout;

  // State sequencing, frame acceptance and watchdog counting.
  always_comb begin
    state_next = state_reg;
    wd_next    = wd_reg;
    accept     = 1'b0;
    timeout    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.Data_Valid) begin
          accept     = 1'b1;
          state_next = START;
        end
      end
      START: begin
        // Watchdog restarts on every entry to DATA.
        wd_next    = '0;
        state_next = DATA;
      end
      DATA: begin
        // ser_done wins over a timeout occurring in the same cycle.
        if (bus.ser_done) begin
          state_next = par_en_reg ? PARITY : STOP;
        end else if (wd_reg == WD_LAST) begin
          timeout    = 1'b1;
          state_next = STOP;
        end else begin
          wd_next = wd_reg + 4'd1;
        end
      end
      PARITY: begin
        state_next = STOP;
      end
      STOP: begin
        // Back-to-back frames skip IDLE entirely.
        if (bus.Data_Valid) begin
          accept     = 1'b1;
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, watchdog and error-pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      wd_reg        <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wd_reg        <= wd_next;
      frame_err_reg <= timeout;
    end
  end

  // Frame contents: captured only on acceptance, stable for the whole frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_reg    <= 8'h00;
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
    end else if (accept) begin
      byte_reg    <= bus.P_DATA;
      par_en_reg  <= bus.PAR_EN;
      par_bit_reg <= (^bus.P_DATA) ^ bus.PAR_TYP;
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    bus.mux_sel = MUX_STOP;
    bus.ser_en  = 1'b0;
    bus.busy    = (state_reg != IDLE);
    case (state_reg)
      START:   bus.mux_sel = MUX_START;
      DATA: begin
        bus.mux_sel = MUX_DATA;
        bus.ser_en  = 1'b1;
      end
      PARITY:  bus.mux_sel = MUX_PARITY;
      default: bus.mux_sel = MUX_STOP;
    endcase
  end

  assign bus.data_reg  = byte_reg;
  assign bus.par_bit   = par_bit_reg;
  assign bus.frame_err = frame_err_reg;

endmodule
